timer_tick_scheduler: RTL and testbench
=======================================

TIMER_TICK_SCHEDULER -- requirements
Module: timer_tick_scheduler

Interface
REQ-001: Parameter NCH, default 4, number of software tick channels (2..8).
REQ-002: Parameter DEFAULT_PERIOD, default 32'd49999, timer period register value programmed after reset (timeout every value+1 clocks).
REQ-003: clk  in  1  single clock; one clock; all logic on rising edge.
REQ-004: reset  in  1  synchronous, active-high reset.
REQ-005: tmr_address  out  3  timer slave word address.
REQ-006: tmr_chipselect  out  1  timer select; high only during a write cycle.
REQ-007: tmr_write_n  out  1  active-low write; low only together with tmr_chipselect.
REQ-008: tmr_writedata  out  16  timer write data.
REQ-009: tmr_irq  in  1  timer interrupt, level, high until status written.
REQ-010: cfg_valid / cfg_ready  in / out  1 / 1  period-change handshake.
REQ-011: cfg_period  in  32  new period register value.
REQ-012: arm_valid  in  1  one-cycle arm command, always accepted.
REQ-013: arm_ch  in  clog2(NCH)  target channel; arm_ticks  in  16  tick count, 0 = disarm; arm_periodic  in  1  auto-reload on expiry.
REQ-014: ch_active  out  NCH  channel armed; ch_event  out  NCH  one-cycle expiry pulse.
REQ-015: tick_count  out  32  free-running tick counter; busy  out  1  FSM not in IDLE.

Function
REQ-016: FSM states INIT_PL, INIT_PH, INIT_CTRL, IDLE, CLR, TICK; every non-IDLE write state lasts exactly one cycle.
REQ-017: INIT_PL writes period[15:0] to address 2; INIT_PH writes period[31:16] to address 3; INIT_CTRL writes 16'h0007 (ITO|CONT|START) to address 1, then IDLE.
REQ-018: After reset, period = DEFAULT_PERIOD; sequence starts first cycle after reset deasserts.
REQ-019: In IDLE, tmr_irq=1 -> CLR (write 16'h0000 to address 0) -> TICK -> IDLE.
REQ-020: In IDLE with tmr_irq=0 and cfg_valid=1: cfg_ready pulses that cycle, cfg_period latched, -> INIT_PL; cfg_ready=0 in all other states.
REQ-021: tmr_irq has priority over cfg_valid in IDLE; a pending cfg is accepted on the next IDLE cycle without irq.
REQ-022: tmr_irq arriving during INIT/CLR/TICK is not lost; it is serviced on return to IDLE (level-held by timer).
REQ-023: TICK: tick_count += 1 modulo 2^32 (wraps FFFFFFFF -> 0); every active channel's remaining count decrements by 1.
REQ-024: Channel whose remaining count is 1 in TICK: ch_event bit pulses that cycle; if periodic, remaining reloads to its stored arm_ticks, else ch_active clears.
REQ-025: Multiple channels may fire in the same TICK; all pulse simultaneously.
REQ-026: arm_valid with arm_ticks!=0: remaining=arm_ticks, stored reload=arm_ticks, periodic flag latched, ch_active set next cycle; arm_ticks=0 clears ch_active, no event.
REQ-027: arm_valid coinciding with TICK on the same channel: arm wins; no decrement, no event for that channel that cycle.
REQ-028: When idle bus: tmr_chipselect=0, tmr_write_n=1, tmr_address=0, tmr_writedata=0.
REQ-029: Reconfiguration does not clear tick_count or channel state.

Reset
REQ-030: reset=1 at any clk edge, including mid-sequence: state=INIT_PL, period=DEFAULT_PERIOD, tick_count=0, ch_active=0, ch_event=0, cfg_ready=0, bus outputs idle values, busy=1.
REQ-031: Reset does not issue writes while asserted; the first write appears in the first cycle after deassertion.

Verification
REQ-032: Release reset -> three consecutive writes: addr2=C34F, addr3=0000, addr1=0007; then busy=0.
REQ-033: Pulse tmr_irq high until status write -> addr0 write of 0000 one cycle after irq seen in IDLE, tick_count 0->1 two cycles later.
REQ-034: Arm ch1 ticks=3 one-shot, arm ch2 ticks=2 periodic, drive 4 ticks -> ch2 events on ticks 2 and 4, ch1 event on tick 3 then ch_active[1]=0.
REQ-035: cfg_valid with period 0001_0000 while tmr_irq high -> CLR/TICK first, then cfg_ready pulse, writes addr2=0000, addr3=0001, addr1=0007.
REQ-036: Force tick_count=FFFFFFFF, one tick -> tick_count=0; arm ch0 ticks=1 same cycle as TICK -> no event, event on following tick.
REQ-037: Assert reset during INIT_PH of a reconfig -> sequence restarts with DEFAULT_PERIOD, all channels inactive.

Source files
------------

// File: rtl/timer_tick_scheduler_if.sv
// Scheduler-to-timer bus, period reconfiguration handshake, channel arm port and status.
// master = scheduler side; slave = timer/software side.
interface timer_tick_scheduler_if #(
    parameter int NCH = 4
);
    localparam int CHW = $clog2(NCH);

    logic [2:0]     tmr_address;
    logic           tmr_chipselect;
    logic           tmr_write_n;
    logic [15:0]    tmr_writedata;
    logic           tmr_irq;

    logic           cfg_valid;
    logic           cfg_ready;
    logic [31:0]    cfg_period;

    logic           arm_valid;
    logic [CHW-1:0] arm_ch;
    logic [15:0]    arm_ticks;
    logic           arm_periodic;

    logic [NCH-1:0] ch_active;
    logic [NCH-1:0] ch_event;
    logic [31:0]    tick_count;
    logic           busy;

    modport master (
        output tmr_address, tmr_chipselect, tmr_write_n, tmr_writedata,
        input  tmr_irq,
        input  cfg_valid, cfg_period,
        output cfg_ready,
        input  arm_valid, arm_ch, arm_ticks, arm_periodic,
        output ch_active, ch_event, tick_count, busy
    );

    modport slave (
        input  tmr_address, tmr_chipselect, tmr_write_n, tmr_writedata,
        output tmr_irq,
        output cfg_valid, cfg_period,
        input  cfg_ready,
        output arm_valid, arm_ch, arm_ticks, arm_periodic,
        input  ch_active, ch_event, tick_count, busy
    );
endinterface

// File: rtl/timer_tick_scheduler.sv
// Programs a hardware timer, turns its interrupts into ticks and counts down NCH software channels.
// One bus write per non-IDLE state; cfg held off (cfg_ready=0) outside IDLE or while irq pending; arm always accepted.
module timer_tick_scheduler #(
    parameter int          NCH            = 4,
    parameter logic [31:0] DEFAULT_PERIOD = 32'd49999
) (
    input  logic                   clk,
    input  logic                   reset,
    timer_tick_scheduler_if.master bus
);
    localparam int CHW = $clog2(NCH);

    typedef enum logic [2:0] {
        INIT_PL,
        INIT_PH,
        INIT_CTRL,
        IDLE,
        CLR,
        TICK
    } state_t;

    state_t         state_q;
    state_t         state_nxt;
    logic [31:0]    period_q;
    logic [31:0]    tick_count_q;
    logic [15:0]    remain_q [NCH];
    logic [15:0]    reload_q [NCH];
    logic [NCH-1:0] active_q;
    logic [NCH-1:0] periodic_q;
    logic [NCH-1:0] arm_hit;
    logic [NCH-1:0] fire;
    logic           cfg_accept;

    // The timer interrupt always wins over a pending reconfiguration.
    assign cfg_accept = (state_q == IDLE) && !bus.tmr_irq && bus.cfg_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= INIT_PL;
        end else begin
            state_q <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            INIT_PL:   state_nxt = INIT_PH;
            INIT_PH:   state_nxt = INIT_CTRL;
            INIT_CTRL: state_nxt = IDLE;
            IDLE: begin
                if (bus.tmr_irq) begin
                    state_nxt = CLR;
                end else if (bus.cfg_valid) begin
                    state_nxt = INIT_PL;
                end
            end
            CLR:       state_nxt = TICK;
            TICK:      state_nxt = IDLE;
            default:   state_nxt = INIT_PL;
        endcase
    end

    always_comb begin
        bus.tmr_chipselect = 1'b0;
        bus.tmr_write_n    = 1'b1;
        bus.tmr_address    = 3'd0;
        bus.tmr_writedata  = 16'h0000;
        bus.cfg_ready      = 1'b0;
        bus.ch_event       = '0;
        bus.busy           = reset || (state_q != IDLE);
        if (!reset) begin
            case (state_q)
                INIT_PL: begin
                    bus.tmr_chipselect = 1'b1;
                    bus.tmr_write_n    = 1'b0;
                    bus.tmr_address    = 3'd2;
                    bus.tmr_writedata  = period_q[15:0];
                end
                INIT_PH: begin
                    bus.tmr_chipselect = 1'b1;
                    bus.tmr_write_n    = 1'b0;
                    bus.tmr_address    = 3'd3;
                    bus.tmr_writedata  = period_q[31:16];
                end
                INIT_CTRL: begin
                    bus.tmr_chipselect = 1'b1;
                    bus.tmr_write_n    = 1'b0;
                    bus.tmr_address    = 3'd1;
                    bus.tmr_writedata  = 16'h0007;
                end
                CLR: begin
                    bus.tmr_chipselect = 1'b1;
                    bus.tmr_write_n    = 1'b0;
                end
                IDLE:    bus.cfg_ready = cfg_accept;
                TICK:    bus.ch_event  = fire;
                default: ;
            endcase
        end
    end

    // A same-cycle arm overrides the tick for that channel.
    always_comb begin
        arm_hit = '0;
        fire    = '0;
        for (int i = 0; i < NCH; i++) begin
            arm_hit[i] = bus.arm_valid && (bus.arm_ch == CHW'(i));
            fire[i]    = (state_q == TICK) && active_q[i] &&
                         (remain_q[i] == 16'd1) && !arm_hit[i];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            period_q     <= DEFAULT_PERIOD;
            tick_count_q <= 32'd0;
        end else begin
            if (cfg_accept) begin
                period_q <= bus.cfg_period;
            end
            if (state_q == TICK) begin
                tick_count_q <= tick_count_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            active_q   <= '0;
            periodic_q <= '0;
            for (int i = 0; i < NCH; i++) begin
                remain_q[i] <= 16'd0;
                reload_q[i] <= 16'd0;
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (arm_hit[i]) begin
                    if (bus.arm_ticks != 16'd0) begin
                        remain_q[i]   <= bus.arm_ticks;
                        reload_q[i]   <= bus.arm_ticks;
                        periodic_q[i] <= bus.arm_periodic;
                        active_q[i]   <= 1'b1;
                    end else begin
                        active_q[i]   <= 1'b0;
                    end
                end else if ((state_q == TICK) && active_q[i]) begin
                    if (remain_q[i] == 16'd1) begin
                        if (periodic_q[i]) begin
                            remain_q[i] <= reload_q[i];
                        end else begin
                            active_q[i] <= 1'b0;
                        end
                    end else begin
                        remain_q[i] <= remain_q[i] - 16'd1;
                    end
                end
            end
        end
    end

    assign bus.tick_count = tick_count_q;
    assign bus.ch_active  = active_q;
endmodule

// File: tb/tb_timer_tick_scheduler.sv
// Directed bench: stimulus pushes expected bus writes and channel events; a negedge monitor pops and compares.
module tb_timer_tick_scheduler;
    localparam int NCH = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    timer_tick_scheduler_if #(.NCH(NCH)) bus ();

    timer_tick_scheduler #(
        .NCH            (NCH),
        .DEFAULT_PERIOD (32'd49999)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [18:0]    wr_q [$];
    logic [NCH-1:0] ev_q [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_wr(input logic [2:0] a, input logic [15:0] d);
        wr_q.push_back({a, d});
    endtask

    // Monitor: every bus write and every event pulse must match the next queued expectation.
    initial begin
        logic [18:0]    exp_wr;
        logic [NCH-1:0] exp_ev;
        forever begin
            @(negedge clk);
            if (bus.tmr_chipselect === 1'b1) begin
                chk("write_n_low", {31'd0, bus.tmr_write_n}, 32'd0);
                if (wr_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_write: got addr %0d data %h expected none", bus.tmr_address, bus.tmr_writedata);
                end else begin
                    exp_wr = wr_q.pop_front();
                    chk("bus_write", {13'd0, bus.tmr_address, bus.tmr_writedata}, {13'd0, exp_wr});
                end
            end else begin
                chk("bus_idle", {12'd0, bus.tmr_write_n, bus.tmr_address, bus.tmr_writedata}, {12'd0, 1'b1, 3'd0, 16'd0});
            end
            if (bus.ch_event !== '0) begin
                if (ev_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_event: got %b expected none", bus.ch_event);
                end else begin
                    exp_ev = ev_q.pop_front();
                    chk("ch_event", {28'd0, bus.ch_event}, {28'd0, exp_ev});
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic arm(input int ch, input logic [15:0] t, input logic per);
        bus.arm_valid    = 1'b1;
        bus.arm_ch       = 2'(ch);
        bus.arm_ticks    = t;
        bus.arm_periodic = per;
        @(posedge clk); #1;
        bus.arm_valid    = 1'b0;
    endtask

    // Called at posedge+1 with the DUT in IDLE; optionally arms a channel during the TICK cycle.
    task automatic do_tick(input logic arm_en, input int ch, input logic [15:0] t, input logic per);
        logic [31:0] tc0;
        tc0 = bus.tick_count;
        bus.tmr_irq = 1'b1;
        @(posedge clk); #1;
        chk("clr_write", {12'd0, bus.tmr_chipselect, bus.tmr_address, bus.tmr_writedata}, {12'd0, 1'b1, 3'd0, 16'h0000});
        bus.tmr_irq = 1'b0;
        @(posedge clk); #1;
        if (arm_en) begin
            bus.arm_valid    = 1'b1;
            bus.arm_ch       = 2'(ch);
            bus.arm_ticks    = t;
            bus.arm_periodic = per;
        end
        chk("busy_in_tick", {31'd0, bus.busy}, 32'd1);
        chk("count_before_tick", bus.tick_count, tc0);
        @(posedge clk); #1;
        bus.arm_valid = 1'b0;
        chk("count_after_tick", bus.tick_count, tc0 + 32'd1);
        chk("idle_after_tick", {31'd0, bus.busy}, 32'd0);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (bus.busy == 1'b0) break;
        end
        chk("wait_idle", {31'd0, bus.busy}, 32'd0);
    endtask

    // Called at posedge+1 right after reset is released.
    task automatic check_init_seq();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("init_write_slot", {31'd0, bus.tmr_chipselect}, 32'd1);
        end
        @(negedge clk);
        chk("idle_after_init", {31'd0, bus.busy}, 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic check_reset_state();
        chk("rst_busy", {31'd0, bus.busy}, 32'd1);
        chk("rst_ch_active", {28'd0, bus.ch_active}, 32'd0);
        chk("rst_ch_event", {28'd0, bus.ch_event}, 32'd0);
        chk("rst_tick_count", bus.tick_count, 32'd0);
        chk("rst_cfg_ready", {31'd0, bus.cfg_ready}, 32'd0);
    endtask

    initial begin
        bus.tmr_irq      = 1'b0;
        bus.cfg_valid    = 1'b0;
        bus.cfg_period   = 32'd0;
        bus.arm_valid    = 1'b0;
        bus.arm_ch       = '0;
        bus.arm_ticks    = 16'd0;
        bus.arm_periodic = 1'b0;

        // Reset state and power-up programming with the default period 49999 = 0x0000C34F.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_state();
        push_wr(3'd2, 16'hC34F);
        push_wr(3'd3, 16'h0000);
        push_wr(3'd1, 16'h0007);
        @(posedge clk); #1;
        reset = 1'b0;
        check_init_seq();

        // First tick: status clear then count 0 -> 1.
        push_wr(3'd0, 16'h0000);
        do_tick(1'b0, 0, 16'd0, 1'b0);
        chk("first_tick_count", bus.tick_count, 32'd1);

        // ch1 one-shot 3, ch2 periodic 2.
        arm(1, 16'd3, 1'b0);
        chk("arm_ch1_active", {28'd0, bus.ch_active}, 32'h2);
        arm(2, 16'd2, 1'b1);
        chk("arm_ch2_active", {28'd0, bus.ch_active}, 32'h6);
        push_wr(3'd0, 16'h0000);
        do_tick(1'b0, 0, 16'd0, 1'b0);
        push_wr(3'd0, 16'h0000);
        ev_q.push_back(4'b0100);
        do_tick(1'b0, 0, 16'd0, 1'b0);
        push_wr(3'd0, 16'h0000);
        ev_q.push_back(4'b0010);
        do_tick(1'b0, 0, 16'd0, 1'b0);
        chk("ch1_cleared", {28'd0, bus.ch_active}, 32'h4);
        push_wr(3'd0, 16'h0000);
        ev_q.push_back(4'b0100);
        do_tick(1'b0, 0, 16'd0, 1'b0);
        chk("ch2_still_active", {28'd0, bus.ch_active}, 32'h4);
        arm(2, 16'd0, 1'b0);
        chk("ch2_disarmed", {28'd0, bus.ch_active}, 32'h0);

        // Reconfiguration requested while irq pending: tick first, then period 0x00010000.
        arm(3, 16'd5, 1'b1);
        push_wr(3'd0, 16'h0000);
        push_wr(3'd2, 16'h0000);
        push_wr(3'd3, 16'h0001);
        push_wr(3'd1, 16'h0007);
        bus.tmr_irq    = 1'b1;
        bus.cfg_valid  = 1'b1;
        bus.cfg_period = 32'h0001_0000;
        @(negedge clk);
        chk("cfg_ready_irq_priority", {31'd0, bus.cfg_ready}, 32'd0);
        @(posedge clk); #1;
        bus.tmr_irq = 1'b0;
        chk("cfg_ready_in_clr", {31'd0, bus.cfg_ready}, 32'd0);
        @(posedge clk); #1;
        chk("cfg_ready_in_tick", {31'd0, bus.cfg_ready}, 32'd0);
        @(posedge clk); #1;
        chk("cfg_ready_pulse", {31'd0, bus.cfg_ready}, 32'd1);
        @(posedge clk); #1;
        bus.cfg_valid = 1'b0;
        chk("cfg_ready_after", {31'd0, bus.cfg_ready}, 32'd0);
        wait_idle();
        chk("reconfig_keeps_count", bus.tick_count, 32'd6);
        chk("reconfig_keeps_channels", {28'd0, bus.ch_active}, 32'h8);

        // Counter wrap, and re-arm of an about-to-fire channel during TICK suppresses its event.
        arm(0, 16'd1, 1'b0);
        chk("arm_ch0_active", {28'd0, bus.ch_active}, 32'h9);
        force dut.tick_count_q = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        release dut.tick_count_q;
        push_wr(3'd0, 16'h0000);
        do_tick(1'b1, 0, 16'd1, 1'b0);
        chk("tick_count_wrap", bus.tick_count, 32'd0);
        chk("ch0_rearmed", {28'd0, bus.ch_active}, 32'h9);
        push_wr(3'd0, 16'h0000);
        ev_q.push_back(4'b0001);
        do_tick(1'b0, 0, 16'd0, 1'b0);
        chk("ch0_fired_cleared", {28'd0, bus.ch_active}, 32'h8);

        // Reset in the middle of a reconfiguration (during INIT_PH).
        push_wr(3'd2, 16'h0003);
        bus.cfg_valid  = 1'b1;
        bus.cfg_period = 32'h0002_0003;
        @(posedge clk); #1;
        bus.cfg_valid = 1'b0;
        @(posedge clk); #1;
        chk("in_init_ph", {29'd0, bus.tmr_address}, 32'd3);
        reset = 1'b1;
        @(negedge clk);
        chk("busy_during_reset", {31'd0, bus.busy}, 32'd1);
        @(posedge clk); #1;
        check_reset_state();
        @(posedge clk); #1;
        push_wr(3'd2, 16'hC34F);
        push_wr(3'd3, 16'h0000);
        push_wr(3'd1, 16'h0007);
        reset = 1'b0;
        check_init_seq();

        repeat (2) @(posedge clk);
        chk("writes_drained", wr_q.size(), 32'd0);
        chk("events_drained", ev_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
